// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART message receiver.
//   rx_state_t  : receive FSM state encoding
//   half_bit    : half a bit period in clk cycles (mid-bit sample offset)
//   parity_calc : parity bit a transmitter would send for the given data
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    function automatic int unsigned half_bit(input int unsigned clks_per_bit);
        return clks_per_bit / 2;
    endfunction

    // Data is zero-extended by the caller; unused upper bits do not change the XOR.
    function automatic logic parity_calc(input logic [31:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter for the UART receiver.
//   clk, reset : system clock, asynchronous active-high reset
//   load_half  : reload to reach the middle of the start bit
//   load_full  : reload for one full bit period
//   tick       : counter has reached zero; the FSM samples and reloads here
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load_half,
    input  logic load_full,
    output logic tick
);

    localparam int unsigned HALF_BIT = half_bit(CLKS_PER_BIT);
    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_half) begin
            cnt_q <= CNT_W'(HALF_BIT - 1);
        end else if (load_full) begin
            cnt_q <= CNT_W'(CLKS_PER_BIT - 1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_msg_rx.sv
// UART receiver that assembles MSG_BYTES characters into one message and
// offers it on a valid/ready handshake.
//   clk, reset  : system clock, asynchronous active-high reset
//   rx          : raw serial input (idle high, asynchronous)
//   msg         : assembled message, first byte in the most significant position
//   msg_valid   : msg holds an unconsumed message; cleared by msg_ready
//   msg_ready   : consumer accept
//   byte_valid  : pulse per accepted character
//   frame_err   : pulse when the stop bit samples low
//   parity_err  : pulse on parity mismatch
//   timeout     : pulse when a partial message is discarded after idling
//   overrun     : pulse when a completed message is dropped (msg_valid still set)
module uart_msg_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned MSG_BYTES    = 3,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = 1'b0,
    parameter int unsigned TIMEOUT_BITS = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    output logic [MSG_BYTES*DATA_BITS-1:0] msg,
    output logic                          msg_valid,
    input  logic                          msg_ready,
    output logic                          byte_valid,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          timeout,
    output logic                          overrun
);

    localparam int unsigned MSG_W     = MSG_BYTES * DATA_BITS;
    localparam int unsigned IDX_W     = $clog2(MSG_BYTES + 1);
    localparam int unsigned BITN_W    = $clog2(DATA_BITS + 1);
    localparam int unsigned TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned TMO_W     = $clog2(TMO_LIMIT + 1);

    // Two-flop synchronizer; resets to the idle line level.
    logic rx_meta, rx_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    logic load_half, load_full, tick;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .load_half(load_half),
        .load_full(load_full),
        .tick     (tick)
    );

    rx_state_t             state_q, state_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [BITN_W-1:0]     bitn_q, bitn_d;
    logic                  par_bad_q, par_bad_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [MSG_W-1:0]      partial_q, partial_d;
    logic [MSG_W-1:0]      msg_q, msg_d;
    logic                  msg_valid_q, msg_valid_d;
    logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic                  byte_valid_q, byte_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  parity_err_q, parity_err_d;
    logic                  timeout_q, timeout_d;
    logic                  overrun_q, overrun_d;
    logic                  handshake;
    logic [MSG_W-1:0]      new_msg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bitn_q       <= '0;
            par_bad_q    <= 1'b0;
            idx_q        <= '0;
            partial_q    <= '0;
            msg_q        <= '0;
            msg_valid_q  <= 1'b0;
            tmo_cnt_q    <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            timeout_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bitn_q       <= bitn_d;
            par_bad_q    <= par_bad_d;
            idx_q        <= idx_d;
            partial_q    <= partial_d;
            msg_q        <= msg_d;
            msg_valid_q  <= msg_valid_d;
            tmo_cnt_q    <= tmo_cnt_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            timeout_q    <= timeout_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        load_half    = 1'b0;
        load_full    = 1'b0;
        shift_d      = shift_q;
        bitn_d       = bitn_q;
        par_bad_d    = par_bad_q;
        idx_d        = idx_q;
        partial_d    = partial_q;
        msg_d        = msg_q;
        msg_valid_d  = msg_valid_q;
        tmo_cnt_d    = '0;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        timeout_d    = 1'b0;
        overrun_d    = 1'b0;

        handshake = msg_valid_q && msg_ready;
        // Partial message with the just-received character appended at the LS end.
        new_msg   = (partial_q << DATA_BITS) | MSG_W'(shift_q);

        if (handshake) begin
            msg_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (!rx_sync) begin
                    // A start bit on the expiry cycle takes priority over the timeout.
                    load_half = 1'b1;
                    state_d   = START;
                end else if (idx_q != '0) begin
                    if (tmo_cnt_q == TMO_W'(TMO_LIMIT - 1)) begin
                        timeout_d = 1'b1;
                        idx_d     = '0;
                        partial_d = '0;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
            end

            START: begin
                if (tick) begin
                    if (rx_sync) begin
                        state_d = IDLE;  // glitch shorter than half a bit
                    end else begin
                        load_full = 1'b1;
                        bitn_d    = '0;
                        par_bad_d = 1'b0;
                        state_d   = DATA;
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    load_full = 1'b1;
                    shift_d   = {rx_sync, shift_q[DATA_BITS-1:1]};
                    if (bitn_q == BITN_W'(DATA_BITS - 1)) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end else begin
                        bitn_d = bitn_q + 1'b1;
                    end
                end
            end

            PARITY: begin
                if (tick) begin
                    load_full = 1'b1;
                    par_bad_d = (rx_sync != parity_calc(32'(shift_q), PARITY_ODD));
                    state_d   = STOP;
                end
            end

            STOP: begin
                if (tick) begin
                    if (!rx_sync) begin
                        frame_err_d = 1'b1;
                        idx_d       = '0;
                        partial_d   = '0;
                        state_d     = WAIT_HIGH;
                    end else if (par_bad_q) begin
                        parity_err_d = 1'b1;
                        idx_d        = '0;
                        partial_d    = '0;
                        state_d      = IDLE;
                    end else begin
                        byte_valid_d = 1'b1;
                        state_d      = IDLE;
                        if (idx_q == IDX_W'(MSG_BYTES - 1)) begin
                            idx_d     = '0;
                            partial_d = '0;
                            // A same-cycle handshake frees the buffer for the new message.
                            if (!msg_valid_q || handshake) begin
                                msg_d       = new_msg;
                                msg_valid_d = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end else begin
                            idx_d     = idx_q + 1'b1;
                            partial_d = new_msg;
                        end
                    end
                end
            end

            WAIT_HIGH: begin
                if (rx_sync) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign msg        = msg_q;
    assign msg_valid  = msg_valid_q;
    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign timeout    = timeout_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_msg_rx.sv
module tb_uart_msg_rx;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1, rx_p = 1'b1;
    logic        msg_ready = 1'b0, msg_ready_p = 1'b0;
    logic [23:0] msg, msg_p;
    logic        msg_valid, byte_valid, frame_err, parity_err, timeout, overrun;
    logic        msg_valid_p, byte_valid_p, frame_err_p, parity_err_p, timeout_p, overrun_p;

    always #5 clk = ~clk;

    uart_msg_rx dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .msg       (msg),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .byte_valid(byte_valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .timeout   (timeout),
        .overrun   (overrun)
    );

    uart_msg_rx #(
        .PARITY_EN (1'b1),
        .PARITY_ODD(1'b0)
    ) dut_p (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx_p),
        .msg       (msg_p),
        .msg_valid (msg_valid_p),
        .msg_ready (msg_ready_p),
        .byte_valid(byte_valid_p),
        .frame_err (frame_err_p),
        .parity_err(parity_err_p),
        .timeout   (timeout_p),
        .overrun   (overrun_p)
    );

    typedef struct {
        logic [7:0]  data;
        bit          stop;
        int          idle;
        int          bv, fe, to, ov;
        bit          push;
        logic [23:0] m;
    } vec_t;

    vec_t        tbl[$];
    logic [23:0] exp_q[$];
    logic [23:0] got_q[$];
    int          n_vec = 0, n_err = 0;
    int          bv_cnt = 0, fe_cnt = 0, to_cnt = 0, ov_cnt = 0;
    int          bvp_cnt = 0, pep_cnt = 0;
    logic        mv_prev = 1'b0;

    // Event monitor: pulse counters and message arrivals (rising msg_valid).
    always @(negedge clk) begin
        if (!reset) begin
            if (byte_valid) bv_cnt++;
            if (frame_err)  fe_cnt++;
            if (timeout)    to_cnt++;
            if (overrun)    ov_cnt++;
            if (byte_valid_p) bvp_cnt++;
            if (parity_err_p) pep_cnt++;
            if (msg_valid && !mv_prev) got_q.push_back(msg);
        end
        mv_prev = msg_valid;
    end

    function automatic vec_t mkv(logic [7:0] d, bit s, int idle, int bv, int fe, int to,
                                 int ov, bit push, logic [23:0] m);
        vec_t v;
        v.data = d; v.stop = s; v.idle = idle;
        v.bv = bv; v.fe = fe; v.to = to; v.ov = ov;
        v.push = push; v.m = m;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx_p = v;
        else     rx = v;
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit use_par,
                              input bit par, input bit stop);
        drive(sel, 1'b0);
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            drive(sel, d[i]);
            wait_clks(CPB);
        end
        if (use_par) begin
            drive(sel, par);
            wait_clks(CPB);
        end
        drive(sel, stop);
        wait_clks(CPB);
        drive(sel, 1'b1);
    endtask

    task automatic drain_sb();
        logic [23:0] g, e;
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_extra_msg: got %06h, required no message", g);
            end else begin
                e = exp_q.pop_front();
                chk("sb_msg", 32'(g), 32'(e));
            end
        end
    endtask

    task automatic apply_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            int bv0, fe0, to0, ov0;
            bv0 = bv_cnt; fe0 = fe_cnt; to0 = to_cnt; ov0 = ov_cnt;
            if (tbl[i].push) exp_q.push_back(tbl[i].m);
            send_frame(1'b0, tbl[i].data, 1'b0, 1'b0, tbl[i].stop);
            wait_clks(tbl[i].idle + 2);
            chk($sformatf("row%0d_byte_valid", i), 32'(bv_cnt - bv0), 32'(tbl[i].bv));
            chk($sformatf("row%0d_frame_err", i),  32'(fe_cnt - fe0), 32'(tbl[i].fe));
            chk($sformatf("row%0d_timeout", i),    32'(to_cnt - to0), 32'(tbl[i].to));
            chk($sformatf("row%0d_overrun", i),    32'(ov_cnt - ov0), 32'(tbl[i].ov));
            drain_sb();
        end
    endtask

    task automatic consume();
        msg_ready = 1'b1;
        wait_clks(1);
        msg_ready = 1'b0;
    endtask

    initial begin
        int bv0, fe0, p0, b0;
        logic [7:0] pb[3];

        //              data   stop idle bv fe to ov push msg
        tbl.push_back(mkv(8'h40, 1, 0,   1, 0, 0, 0, 0, 24'h0));       // 0
        tbl.push_back(mkv(8'h7F, 1, 0,   1, 0, 0, 0, 0, 24'h0));       // 1
        tbl.push_back(mkv(8'h0A, 1, 0,   1, 0, 0, 0, 1, 24'h407F0A));  // 2
        tbl.push_back(mkv(8'h11, 1, 0,   1, 0, 0, 0, 0, 24'h0));       // 3
        tbl.push_back(mkv(8'h22, 0, 32,  0, 1, 0, 0, 0, 24'h0));       // 4 bad stop
        tbl.push_back(mkv(8'h01, 1, 0,   1, 0, 0, 0, 0, 24'h0));       // 5
        tbl.push_back(mkv(8'h02, 1, 0,   1, 0, 0, 0, 0, 24'h0));       // 6
        tbl.push_back(mkv(8'h03, 1, 0,   1, 0, 0, 0, 1, 24'h010203));  // 7
        tbl.push_back(mkv(8'h04, 1, 0,   1, 0, 0, 0, 0, 24'h0));       // 8
        tbl.push_back(mkv(8'h05, 1, 0,   1, 0, 0, 0, 0, 24'h0));       // 9
        tbl.push_back(mkv(8'h06, 1, 0,   1, 0, 0, 1, 0, 24'h0));       // 10 overrun
        tbl.push_back(mkv(8'h55, 1, 600, 1, 0, 1, 0, 0, 24'h0));       // 11 then idle
        tbl.push_back(mkv(8'hAA, 1, 0,   1, 0, 0, 0, 0, 24'h0));       // 12
        tbl.push_back(mkv(8'hBB, 1, 0,   1, 0, 0, 0, 0, 24'h0));       // 13
        tbl.push_back(mkv(8'hCC, 1, 0,   1, 0, 0, 0, 1, 24'hAABBCC));  // 14
        tbl.push_back(mkv(8'h0D, 1, 0,   1, 0, 0, 0, 0, 24'h0));       // 15
        tbl.push_back(mkv(8'h0E, 1, 0,   1, 0, 0, 0, 0, 24'h0));       // 16
        tbl.push_back(mkv(8'h0F, 1, 0,   1, 0, 0, 0, 1, 24'h0D0E0F));  // 17

        // Reset state
        wait_clks(3);
        chk("rst_flags", 32'({msg_valid, byte_valid, frame_err, parity_err, timeout, overrun}),
            32'h0);
        chk("rst_msg", 32'(msg), 32'h0);
        reset = 1'b0;
        wait_clks(10);
        chk("idle_flags", 32'({msg_valid, byte_valid, frame_err, timeout, overrun}), 32'h0);

        // Back-to-back message, held while msg_ready is low
        apply_rows(0, 2);
        chk("held_valid", 32'(msg_valid), 32'h1);
        chk("held_msg", 32'(msg), 32'h407F0A);
        wait_clks(20);
        chk("held_valid_later", 32'(msg_valid), 32'h1);
        chk("held_msg_later", 32'(msg), 32'h407F0A);
        consume();
        chk("valid_after_accept", 32'(msg_valid), 32'h0);

        // False start: 5-cycle low glitch
        bv0 = bv_cnt; fe0 = fe_cnt;
        rx = 1'b0;
        wait_clks(5);
        rx = 1'b1;
        wait_clks(40);
        chk("glitch_byte_valid", 32'(bv_cnt - bv0), 32'h0);
        chk("glitch_frame_err", 32'(fe_cnt - fe0), 32'h0);

        // Framing error resync, then a pending message causes an overrun
        apply_rows(3, 10);
        chk("ovr_msg_kept", 32'(msg), 32'h010203);
        chk("ovr_valid_kept", 32'(msg_valid), 32'h1);
        consume();

        // Inter-byte timeout discards the lone 0x55
        apply_rows(11, 14);

        // Reset during DATA of the second byte, with a message pending
        send_frame(1'b0, 8'h01, 1'b0, 1'b0, 1'b1);
        wait_clks(2);
        rx = 1'b0; wait_clks(CPB);   // start
        rx = 1'b0; wait_clks(CPB);   // d0
        rx = 1'b1; wait_clks(CPB);   // d1
        reset = 1'b1;
        wait_clks(1);
        chk("midrst_flags",
            32'({msg_valid, byte_valid, frame_err, parity_err, timeout, overrun}), 32'h0);
        chk("midrst_msg", 32'(msg), 32'h0);
        wait_clks(2);
        reset = 1'b0;
        wait_clks(50);
        apply_rows(15, 17);
        chk("post_rst_msg", 32'(msg), 32'h0D0E0F);

        // Parity instance: good byte, bad-parity byte, then a clean message
        send_frame(1'b1, 8'h77, 1'b1, ^8'h77, 1'b1);
        wait_clks(4);
        p0 = pep_cnt; b0 = bvp_cnt;
        send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);  // even parity of 0x03 is 0
        wait_clks(4);
        chk("par_err_pulse", 32'(pep_cnt - p0), 32'h1);
        chk("par_bad_no_byte", 32'(bvp_cnt - b0), 32'h0);
        pb[0] = 8'h12; pb[1] = 8'h34; pb[2] = 8'h56;
        p0 = pep_cnt; b0 = bvp_cnt;
        for (int i = 0; i < 3; i++) begin
            send_frame(1'b1, pb[i], 1'b1, ^pb[i], 1'b1);
            wait_clks(2);
        end
        wait_clks(4);
        chk("par_good_bytes", 32'(bvp_cnt - b0), 32'h3);
        chk("par_good_no_err", 32'(pep_cnt - p0), 32'h0);
        chk("par_msg_valid", 32'(msg_valid_p), 32'h1);
        chk("par_msg", 32'(msg_p), 32'h123456);

        drain_sb();
        chk("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_msg_rx.md
Name: uart_msg_rx

Overview:
Parametrised UART receive path that assembles a fixed-length command message from consecutive bytes, e.g. lmotor/rmotor/dur, and hands it to the motor-control logic over a valid/ready handshake. It replaces the single-rate receive path with the following additions:
- Mid-bit sampling and false-start rejection.
- Optional parity.
- Framing-error resynchronisation.
- Inter-byte timeout.
- A one-message holding buffer with overrun detection.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit (even, >=4)
DATA_BITS, 8, data bits per character, LSB first
MSG_BYTES, 3, characters per message (>=1)
PARITY_EN, 0, 1 = a parity bit follows the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even (only used when PARITY_EN=1)
TIMEOUT_BITS, 32, idle bit-periods allowed between characters of one message

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx  in  1  raw serial line; idles high; asynchronous to clk
msg  out  MSG_BYTES*DATA_BITS  assembled message; first received byte occupies the MS position
msg_valid  out  1  msg holds an unconsumed message
msg_ready  in  1  consumer accepts msg on a cycle where msg_valid&&msg_ready
byte_valid  out  1  one-cycle pulse for each accepted character
frame_err  out  1  one-cycle pulse when the stop bit samples 0
parity_err  out  1  one-cycle pulse on parity mismatch
timeout  out  1  one-cycle pulse when a partial message is discarded on idle
overrun  out  1  one-cycle pulse when a completed message is dropped because msg_valid is still set

Behaviour:
Input and reset:
- rx passes through a 2-flop synchronizer; both flops reset to 1.
- Reset (async, active-high) takes effect mid-frame too. It sets all outputs and pulses to 0, msg to 0, state to IDLE, and byte index to 0.

State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> (IDLE | WAIT_HIGH).
- IDLE: synced rx==0 loads the bit counter and enters START.
- START: after CLKS_PER_BIT/2 cycles, resample.
  - Sample 1: false start; return to IDLE with no pulse.
  - Sample 0: enter DATA.
- DATA: sample every CLKS_PER_BIT cycles, DATA_BITS samples, shifting in LSB first.
- PARITY: present only if PARITY_EN; one sample. Mismatch is recorded.
- STOP: one sample.
  - Sample 0: frame_err pulse, character discarded, byte index cleared to 0, go to WAIT_HIGH.
  - Sample 1 with parity mismatch: parity_err pulse, character discarded, byte index cleared, go to IDLE.
  - Otherwise: byte_valid pulse on the cycle after the stop sample, character shifted into the partial message, index incremented, go to IDLE.
- WAIT_HIGH: stay until synced rx==1, then go to IDLE.

Message completion:
- When the index reaches MSG_BYTES, the message is complete. On the same cycle as the final byte_valid:
  - If msg_valid==0: load msg and set msg_valid.
  - If msg_valid==1 and no handshake is occurring on that cycle: drop the new message and pulse overrun.
  - If a handshake is occurring on that cycle: the new message loads and msg_valid stays 1.
- Index returns to 0 in every case.
- msg_valid clears on msg_valid&&msg_ready.
- msg is stable while msg_valid=1.

Inter-byte timeout:
- Counter runs while in IDLE with index>0.
- After TIMEOUT_BITS*CLKS_PER_BIT cycles with no start bit: clear index and pulse timeout.
- A start bit arriving on the expiry cycle wins: no timeout pulse.

Latency: the line idle at 1 adds no extra cycles. A complete message appears 3 clk cycles after the final stop-bit sample point (2 synchronizer cycles + 1 register cycle).

Width rules:
- Bit counter is $clog2(CLKS_PER_BIT) bits.
- Byte index is $clog2(MSG_BYTES+1) bits.
- Timeout counter is sized to hold TIMEOUT_BITS*CLKS_PER_BIT.
- No counter wraps in normal operation; each is reloaded at every state entry.

Decomposition:
- Package uart_pkg holds:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH).
  - Function parity_calc(data, odd).
  - Constant HALF_BIT = CLKS_PER_BIT/2, defined as a localparam via a package function.
- Sub-module uart_bit_timer(clk, reset, load_half, load_full, tick) owns the bit counter and tick generation. The FSM, message assembly and handshake live in the parent.

Test Plan:
Default parameters unless stated (CLKS_PER_BIT=16, MSG_BYTES=3).
- Send 0x40, 0x7F, 0x0A back-to-back, msg_ready=0 -> three byte_valid pulses; msg=0x407F0A, msg_valid=1 held; msg_ready=1 for 1 cycle -> msg_valid=0 next cycle.
- rx low for 5 cycles then high -> no byte_valid, no frame_err, FSM back in IDLE.
- Send 0x11, then 0x22 with stop=0, then 0x01, 0x02, 0x03 -> frame_err once; msg=0x010203.
- Send 0x55, then idle 32*16+1 cycles, then 0xAA, 0xBB, 0xCC -> timeout pulse once; msg=0xAABBCC.
- Message 0x010203 pending (msg_ready=0), then send 0x040506 -> overrun pulse; msg stays 0x010203.
- PARITY_EN=1, PARITY_ODD=0: send 0x03 with parity bit 1 -> parity_err, index 0. Separately, assert reset during DATA of byte 2 -> all outputs 0; the next 3 clean bytes form a message.
